// File: rtl/ddr_wr_buf_pkg.sv
// Shared types and derived geometry for the DDR line write buffer.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package ddr_wr_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } wr_state_t;

  // Ring of packed 256-bit DDR words between the pixel side and the burst side.
  localparam int RING_DEPTH = 512;
  localparam int RING_AW    = 9;

  // 128-bit input words per video line.
  function automatic int calc_in_line(input int h_num, input int pix_width);
    return h_num * pix_width / 128;
  endfunction

  // DDR words per line burst: two input words per DDR word.
  function automatic int calc_wr_len(input int in_line);
    return in_line / 2;
  endfunction

  // Address stride between consecutive lines, in DQ-width units.
  function automatic int calc_line_offset(input int wr_len, input int dq_width);
    return wr_len * 256 / dq_width;
  endfunction

endpackage

// File: rtl/wr_fram_buf.sv
// Simple dual-port RAM holding the packed line data, one write and one read port.
// Latency: read data is registered, valid the cycle after rd_en.
// Backpressure: none; caller guarantees it never writes a full ring or reads an empty one.
module wr_fram_buf
  import ddr_wr_buf_pkg::*;
#(
  parameter int DW = 256,
  parameter int AW = RING_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output cleared on reset so ddr_wdata starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ddr_wr_buf.sv
// Packs 128-bit pixel word pairs into 256-bit words and writes each line to DDR as one burst, ping-ponging frame banks.
// Latency: request two cycles after a line's worth of data is buffered; write data one cycle after ddr_wdata_req.
// Backpressure: none upstream; input words arriving while the ring is full are dropped and flagged (o_ovf, o_drop_cnt with DDR_WR_BUF_DROP_CNT_EN).
module ddr_wr_buf
  import ddr_wr_buf_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 27,
  parameter logic [31:0] ADDR_OFFSET     = 32'h0000_0000,
  parameter int          H_NUM           = 1920,
  parameter int          V_NUM           = 1080,
  parameter int          DQ_WIDTH        = 32,
  parameter int          LEN_WIDTH       = 16,
  parameter int          PIX_WIDTH       = 24,
  parameter int          LINE_ADDR_WIDTH = 21
) (
  input  logic                       ddr_clk,
  input  logic                       ddr_rst,
  input  logic                       init_done,
  input  logic                       vin_fsync,
  input  logic                       vin_de,
  input  logic [127:0]               vin_data,
  output logic                       ddr_wreq,
  output logic [ADDR_WIDTH-1:0]      ddr_waddr,
  output logic [LEN_WIDTH-1:0]       ddr_wr_len,
  input  logic                       ddr_wrdy,
  input  logic                       ddr_wdata_req,
  output logic [8*DQ_WIDTH-1:0]      ddr_wdata,
  input  logic                       ddr_wdone,
  output logic                       o_wr_frame_bit,
  output logic                       o_ovf
`ifdef DDR_WR_BUF_DROP_CNT_EN
  ,
  output logic [15:0]                o_drop_cnt
`endif
);

  localparam int IN_LINE     = calc_in_line(H_NUM, PIX_WIDTH);
  localparam int WR_LEN      = calc_wr_len(IN_LINE);
  localparam int LINE_OFFSET = calc_line_offset(WR_LEN, DQ_WIDTH);
  localparam int PW          = RING_AW + 1;

  wr_state_t                  state, state_nxt;
  logic                       fsync_q, fsync_rise, restart_pend, restart;
  logic [PW-1:0]              wptr, rptr, fill_c, fill_q;
  logic                       ring_full, ring_we, ring_re, re_q, drop, go_req;
  logic                       pack_phase;
  logic [127:0]               pack_lo;
  logic [LEN_WIDTH-1:0]       rd_cnt;
  logic [15:0]                line_cnt;
  logic [LINE_ADDR_WIDTH-1:0] line_addr;

  assign fill_c     = wptr - rptr;
  assign ring_full  = (fill_c == PW'(RING_DEPTH));
  assign fsync_rise = vin_fsync & ~fsync_q;
  // A frame restart only takes effect between bursts.
  assign restart    = (state == ST_IDLE) && (fsync_rise || restart_pend);
  assign ring_we    = vin_de && pack_phase && !ring_full && !restart;
  assign drop       = vin_de && ring_full && !restart;
  assign ring_re    = (state == ST_DATA) && ddr_wdata_req && (rd_cnt < LEN_WIDTH'(WR_LEN));
  // re_q masks the one cycle where fill_q has not yet seen the final read of a burst.
  assign go_req     = init_done && (fill_q >= PW'(WR_LEN)) && (line_cnt < 16'(V_NUM))
                      && !restart_pend && !fsync_rise && !re_q;
  assign ddr_wr_len = LEN_WIDTH'(WR_LEN);

  // Burst FSM state register.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Burst FSM next-state: wait for a full line, handshake the request, stream until done.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go_req)    state_nxt = ST_REQ;
      ST_REQ:  if (ddr_wrdy)  state_nxt = ST_DATA;
      ST_DATA: if (ddr_wdone) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Burst FSM outputs: request is held for the whole REQ state.
  always_comb begin
    ddr_wreq = 1'b0;
    if (state == ST_REQ) ddr_wreq = 1'b1;
  end

  // Burst address captured on REQ entry so it stays put until ddr_wdone.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) ddr_waddr <= '0;
    else if (state == ST_IDLE && go_req)
      ddr_waddr <= ADDR_WIDTH'({o_wr_frame_bit, line_addr}) + ADDR_WIDTH'(ADDR_OFFSET);
  end

  // Packing, ring pointers, line/bank bookkeeping and frame restart.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      fsync_q        <= 1'b0;
      restart_pend   <= 1'b0;
      wptr           <= '0;
      rptr           <= '0;
      fill_q         <= '0;
      re_q           <= 1'b0;
      pack_phase     <= 1'b0;
      pack_lo        <= '0;
      rd_cnt         <= '0;
      line_cnt       <= '0;
      line_addr      <= '0;
      o_wr_frame_bit <= 1'b0;
      o_ovf          <= 1'b0;
    end else begin
      fsync_q <= vin_fsync;
      re_q    <= ring_re;
      fill_q  <= restart ? '0 : fill_c;

      if (state != ST_DATA) rd_cnt <= '0;
      else if (ring_re)     rd_cnt <= rd_cnt + 1'b1;

      if (restart) begin
        // A word arriving with the restart is the first word of the new frame.
        wptr         <= '0;
        rptr         <= '0;
        pack_phase   <= vin_de;
        if (vin_de) pack_lo <= vin_data;
        line_cnt     <= '0;
        line_addr    <= '0;
        o_ovf        <= 1'b0;
        restart_pend <= 1'b0;
      end else begin
        if (fsync_rise && state != ST_IDLE) restart_pend <= 1'b1;

        if (drop) begin
          o_ovf <= 1'b1;
        end else if (vin_de && !pack_phase) begin
          pack_lo    <= vin_data;
          pack_phase <= 1'b1;
        end else if (ring_we) begin
          wptr       <= wptr + 1'b1;
          pack_phase <= 1'b0;
        end

        if (ring_re) rptr <= rptr + 1'b1;

        if (state == ST_DATA && ddr_wdone) begin
          if (line_cnt == 16'(V_NUM - 1)) begin
            line_cnt       <= '0;
            line_addr      <= '0;
            o_wr_frame_bit <= ~o_wr_frame_bit;
          end else begin
            line_cnt  <= line_cnt + 1'b1;
            line_addr <= line_addr + LINE_ADDR_WIDTH'(LINE_OFFSET);
          end
        end
      end
    end
  end

`ifdef DDR_WR_BUF_DROP_CNT_EN
  // Saturating count of input words lost to a full ring in the current frame.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst)                        o_drop_cnt <= '0;
    else if (restart)                   o_drop_cnt <= '0;
    else if (drop && o_drop_cnt != '1)  o_drop_cnt <= o_drop_cnt + 1'b1;
  end
`endif

  wr_fram_buf #(
    .DW (8*DQ_WIDTH),
    .AW (RING_AW)
  ) u_ring (
    .clk     (ddr_clk),
    .rst     (ddr_rst),
    .wr_en   (ring_we),
    .wr_addr (wptr[RING_AW-1:0]),
    .wr_data ({vin_data, pack_lo}),
    .rd_en   (ring_re),
    .rd_addr (rptr[RING_AW-1:0]),
    .rd_data (ddr_wdata)
  );

endmodule
